// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// The rx pin is synchronised, and bit timing is phase-locked to the detected start edge.
// A framing error or reset sends the receiver to HUNT. It then waits for 16 idle ticks
// before it accepts another start edge.
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, rx_s;
  logic [PW-1:0] presc_q, presc_d;
  logic          os_tick;
  logic [3:0]    tc_q, tc_d;
  logic          v7_q, v7_d, v8_q, v8_d;
  logic          maj, decide, hunt_done;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          done_q, done_d, ferr_q, ferr_d;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s      = sync2_q;
  assign os_tick   = (presc_q == PRESC_MAX);
  // The vote is decided on the third sample tick, using the live sample as the third vote
  assign decide    = os_tick && (tc_q == 4'd9);
  assign maj       = (v7_q & v8_q) | (v7_q & rx_s) | (v8_q & rx_s);
  assign hunt_done = os_tick && rx_s && (tc_q == 4'd15);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:  if (hunt_done) state_d = IDLE;
      IDLE:  if (!rx_s) state_d = START;
      START: if (decide) state_d = maj ? IDLE : DATA;
      DATA:  if (decide && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:  if (decide) state_d = maj ? IDLE : HUNT;
      default: state_d = HUNT;
    endcase
  end

  // FSM outputs: busy flag and next values of the registered result outputs
  always_comb begin
    rx_busy   = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    done_d    = (state_q == STOP) && decide && maj;
    ferr_d    = (state_q == STOP) && decide && !maj;
    rx_data_d = done_d ? shift_q : rx_data_q;
  end

  // Datapath next state: prescaler, tick counter, vote samples, shift register
  always_comb begin
    presc_d   = os_tick ? '0 : presc_q + PW'(1);
    tc_d      = tc_q;
    v7_d      = v7_q;
    v8_d      = v8_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      HUNT: begin
        // tc counts consecutive high ticks here; any low restarts the count
        if (os_tick) tc_d = (!rx_s || (tc_q == 4'd15)) ? 4'd0 : tc_q + 4'd1;
      end
      IDLE: begin
        tc_d = 4'd0;
        // Re-phase the prescaler to the start edge
        if (!rx_s) presc_d = '0;
      end
      START, DATA, STOP: begin
        // tc wraps 15->0, so bit boundaries stay every 16 ticks from the edge
        if (os_tick) tc_d = tc_q + 4'd1;
        if (os_tick && (tc_q == 4'd7)) v7_d = rx_s;
        if (os_tick && (tc_q == 4'd8)) v8_d = rx_s;
        if (decide) begin
          if (state_q == START) bit_idx_d = 3'd0;
          if (state_q == DATA) begin
            shift_d[bit_idx_q] = maj;
            bit_idx_d          = bit_idx_q + 3'd1;
          end
          if (state_q == STOP) tc_d = 4'd0;
        end
      end
      default: tc_d = 4'd0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      tc_q      <= 4'd0;
      v7_q      <= 1'b1;
      v8_q      <= 1'b1;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tc_q      <= tc_d;
      v7_q      <= v7_d;
      v8_q      <= v8_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at DIV=1 (16 clk per bit); rx driven by a simple 8N1 line model.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, rx_busy;

  uart_rx_os16 #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, both_cnt = 0, busy_cnt = 0, done_cyc = 0;
  logic [7:0] cap_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      cap_data = rx_data;
      done_cyc = cyc;
      $display("rx_done   byte=%h cycle=%0d", rx_data, cyc);
    end
    if (frame_err) begin
      ferr_cnt++;
      $display("frame_err cycle=%0d", cyc);
    end
    if (rx_done && frame_err) both_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    drive(stop_b, 16);
  endtask

  int d0, f0, b0, first_cyc;
  logic [7:0] first_data;

  initial begin
    // Reset
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_done", rx_done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 320);

    // 1: single frame 0xF0
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    send_frame(8'hF0, 1'b1);
    drive(1'b1, 16);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_data", cap_data, 8'hF0);
    check("t1_rx_data_port", rx_data, 8'hF0);
    check("t1_no_frame_err", ferr_cnt - f0, 0);
    check("t1_busy_cycles", busy_cnt - b0, 154);

    // 2: back-to-back 0xDD, 0x55 with zero gap
    d0 = done_cnt;
    send_frame(8'hDD, 1'b1);
    first_cyc  = done_cyc;
    first_data = cap_data;
    send_frame(8'h55, 1'b1);
    drive(1'b1, 16);
    check("t2_done_count", done_cnt - d0, 2);
    check("t2_first_data", first_data, 8'hDD);
    check("t2_second_data", cap_data, 8'h55);
    check("t2_spacing", done_cyc - first_cyc, 160);

    // 3: 4-clk glitch, then a frame soon after (must be accepted from IDLE)
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    drive(1'b0, 4);
    drive(1'b1, 14);
    check("t3_busy_short", ((busy_cnt - b0) >= 1) && ((busy_cnt - b0) <= 12), 1'b1);
    check("t3_no_done", done_cnt - d0, 0);
    check("t3_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h96, 1'b1);
    drive(1'b1, 16);
    check("t3_next_frame_count", done_cnt - d0, 1);
    check("t3_next_frame_data", cap_data, 8'h96);

    // 4: framing error, then a too-early frame (ignored), then a clean frame
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    check("t4_ferr_count", ferr_cnt - f0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_data_kept", rx_data, 8'h96);
    drive(1'b1, 8);
    send_frame(8'h00, 1'b1);
    drive(1'b1, 20);
    check("t4_early_frame_ignored", done_cnt - d0, 0);
    check("t4_data_still_kept", rx_data, 8'h96);
    send_frame(8'hC3, 1'b1);
    drive(1'b1, 16);
    check("t4_late_frame_count", done_cnt - d0, 1);
    check("t4_late_frame_data", cap_data, 8'hC3);
    check("t4_ferr_total", ferr_cnt - f0, 1);

    // 5: reset in the middle of data bit 3 of 0x11; the line model aborts the frame
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b0, 8);
    @(posedge clk);
    #2;
    check("t5_busy_before_reset", rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_rst_rx_data", rx_data, 8'h00);
    check("t5_rst_rx_done", rx_done, 1'b0);
    check("t5_rst_frame_err", frame_err, 1'b0);
    check("t5_rst_rx_busy", rx_busy, 1'b0);
    d0 = done_cnt; f0 = ferr_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 5);
    drive(1'b1, 320);
    check("t5_no_done_after", done_cnt - d0, 0);
    check("t5_no_ferr_after", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 16);
    check("t5_recover_count", done_cnt - d0, 1);
    check("t5_recover_data", rx_data, 8'h3C);

    // 6: 0x0F with a 1-clk inversion at the middle vote sample of data bit 2
    d0 = done_cnt;
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b1, 9);
    drive(1'b0, 1);
    drive(1'b1, 6);
    drive(1'b1, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    check("t6_done_count", done_cnt - d0, 1);
    check("t6_majority_data", cap_data, 8'h0F);
    check("never_done_and_ferr", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
